// File: rtl/pit_bus_sequencer_if.sv
// Bundle of signals between the system-side requester, the pit_bus_sequencer and
// the 8254 data pins. slave = sequencer view; master = requester plus timer-chip side.
interface pit_bus_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_sel;
  logic [2:0]  cmd_mode;
  logic        cmd_bcd;
  logic [1:0]  cmd_rw;
  logic [15:0] cmd_count;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_data;
  logic        pit_cs_n;
  logic        pit_rd_n;
  logic        pit_wr_n;
  logic [1:0]  pit_a;
  logic [7:0]  pit_d_out;
  logic        pit_d_oe;
  logic [7:0]  pit_d_in;

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_mode, cmd_bcd, cmd_rw, cmd_count, pit_d_in,
    output cmd_ready, rsp_valid, rsp_err, rsp_data,
           pit_cs_n, pit_rd_n, pit_wr_n, pit_a, pit_d_out, pit_d_oe
  );

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_mode, cmd_bcd, cmd_rw, cmd_count, pit_d_in,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data,
           pit_cs_n, pit_rd_n, pit_wr_n, pit_a, pit_d_out, pit_d_oe
  );
endinterface

// File: rtl/pit_bus_sequencer.sv
// 8254 bus master: expands one captured high-level command into a sequence of
// control/count writes and reads with programmable setup/strobe/hold timing.
module pit_bus_sequencer #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic clk,
  input  logic rst_n,
  pit_bus_sequencer_if.slave bus
);

  localparam int CW = 16;
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  localparam logic [1:0] OP_WR    = 2'b00;
  localparam logic [1:0] OP_LATCH = 2'b01;
  localparam logic [1:0] OP_STAT  = 2'b10;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP, RESP, ERR} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  sel;
    logic [2:0]  mode;
    logic        bcd;
    logic [1:0]  rw;
    logic [15:0] count;
  } cmd_t;

  state_t        state, nstate;
  cmd_t          cmd;
  logic [1:0]    step;
  logic [CW-1:0] cnt;
  logic [15:0]   rd_buf;
  logic [15:0]   rsp_data_q;

  logic          accept, legal;
  logic [7:0]    ctrl_word;
  logic          cur_rd, cur_hi, last_step;
  logic [1:0]    cur_a;
  logic [7:0]    cur_wd;
  logic          strobe_end;

  assign accept = bus.cmd_valid && (state == IDLE);
  assign legal  = (bus.cmd_op != 2'b11) && (bus.cmd_sel != 2'b11) &&
                  !((bus.cmd_op != OP_STAT) && (bus.cmd_rw == 2'b00));
  assign strobe_end = (state == STROBE) && (cnt == STROBE_LAST);

  // Step 0 is always the control-word write; later steps hit the counter port.
  always_comb begin
    case (cmd.op)
      OP_WR:    ctrl_word = {cmd.sel, cmd.rw, cmd.mode, cmd.bcd};
      OP_LATCH: ctrl_word = {cmd.sel, 6'b0};
      default:  ctrl_word = {2'b11, 1'b1, 1'b0, cmd.sel == 2'd2, cmd.sel == 2'd1,
                             cmd.sel == 2'd0, 1'b0};
    endcase
    cur_rd = 1'b0;
    cur_a  = 2'b11;
    cur_wd = ctrl_word;
    cur_hi = (step == 2'd2) || ((cmd.rw == 2'b10) && (cmd.op != OP_STAT));
    if (step != 2'd0) begin
      cur_a  = cmd.sel;
      cur_rd = (cmd.op != OP_WR);
      cur_wd = cur_rd ? 8'h00 : (cur_hi ? cmd.count[15:8] : cmd.count[7:0]);
    end
    if (cmd.op == OP_STAT) last_step = (step == 2'd1);
    else if (cmd.rw == 2'b11) last_step = (step == 2'd2);
    else last_step = (step == 2'd1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = legal ? SETUP : ERR;
      SETUP:   if (cnt == SETUP_LAST) nstate = STROBE;
      STROBE:  if (cnt == STROBE_LAST) nstate = HOLD;
      HOLD:    if (cnt == HOLD_LAST) nstate = GAP;
      GAP:     nstate = last_step ? RESP : SETUP;
      RESP:    nstate = IDLE;
      ERR:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs: address/data are only driven while cs_n is low.
  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP) || (state == ERR);
    bus.rsp_err   = (state == ERR);
    bus.rsp_data  = rsp_data_q;
    bus.pit_cs_n  = 1'b1;
    bus.pit_rd_n  = 1'b1;
    bus.pit_wr_n  = 1'b1;
    bus.pit_a     = 2'b00;
    bus.pit_d_out = 8'h00;
    bus.pit_d_oe  = 1'b0;
    if ((state == SETUP) || (state == STROBE) || (state == HOLD)) begin
      bus.pit_cs_n  = 1'b0;
      bus.pit_a     = cur_a;
      bus.pit_d_out = cur_wd;
      bus.pit_d_oe  = !cur_rd;
      if (state == STROBE) begin
        bus.pit_rd_n = !cur_rd;
        bus.pit_wr_n = cur_rd;
      end
    end
  end

  // Datapath: phase counter, step index, captured command, read assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd        <= '0;
      step       <= 2'd0;
      cnt        <= '0;
      rd_buf     <= 16'h0000;
      rsp_data_q <= 16'h0000;
    end else begin
      cnt <= (nstate != state) ? '0 : cnt + CW'(1);
      if (accept) begin
        cmd    <= '{op: bus.cmd_op, sel: bus.cmd_sel, mode: bus.cmd_mode, bcd: bus.cmd_bcd,
                    rw: bus.cmd_rw, count: bus.cmd_count};
        step   <= 2'd0;
        rd_buf <= 16'h0000;
        if (!legal) rsp_data_q <= 16'h0000;
      end
      if (strobe_end && cur_rd) begin
        if (cur_hi) rd_buf[15:8] <= bus.pit_d_in;
        else        rd_buf[7:0]  <= bus.pit_d_in;
      end
      if (state == GAP) begin
        if (last_step) rsp_data_q <= (cmd.op == OP_WR) ? 16'h0000 : rd_buf;
        else           step <= step + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pit_bus_sequencer.sv
// Bench for pit_bus_sequencer: directed and random commands against a transaction-level
// model of the expected 8254 bus cycles, with a passive bus monitor and timer data model.
module tb_pit_bus_sequencer;
  localparam int SETUP = 1;
  localparam int HOLD  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  cv = 2'b00;
  logic [1:0]  c_op = 0, c_sel = 0, c_rw = 0;
  logic [2:0]  c_mode = 0;
  logic        c_bcd = 0;
  logic [15:0] c_cnt = 0;
  logic [7:0]  d_in = 0;

  pit_bus_sequencer_if ifa();
  pit_bus_sequencer_if ifb();

  assign ifa.cmd_valid = cv[0];  assign ifb.cmd_valid = cv[1];
  assign ifa.cmd_op = c_op;      assign ifb.cmd_op = c_op;
  assign ifa.cmd_sel = c_sel;    assign ifb.cmd_sel = c_sel;
  assign ifa.cmd_mode = c_mode;  assign ifb.cmd_mode = c_mode;
  assign ifa.cmd_bcd = c_bcd;    assign ifb.cmd_bcd = c_bcd;
  assign ifa.cmd_rw = c_rw;      assign ifb.cmd_rw = c_rw;
  assign ifa.cmd_count = c_cnt;  assign ifb.cmd_count = c_cnt;
  assign ifa.pit_d_in = d_in;    assign ifb.pit_d_in = d_in;

  pit_bus_sequencer #(.SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  pit_bus_sequencer #(.SETUP_CYCLES(1), .STROBE_CYCLES(3), .HOLD_CYCLES(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic [1:0] cs_n, rd_n, wr_n, d_oe, rv, re, rdy, stb;
  logic [1:0][1:0]  pa;
  logic [1:0][7:0]  dout;
  logic [1:0][15:0] rdat;
  assign cs_n = {ifb.pit_cs_n, ifa.pit_cs_n};
  assign rd_n = {ifb.pit_rd_n, ifa.pit_rd_n};
  assign wr_n = {ifb.pit_wr_n, ifa.pit_wr_n};
  assign d_oe = {ifb.pit_d_oe, ifa.pit_d_oe};
  assign rv   = {ifb.rsp_valid, ifa.rsp_valid};
  assign re   = {ifb.rsp_err, ifa.rsp_err};
  assign rdy  = {ifb.cmd_ready, ifa.cmd_ready};
  assign pa   = {ifb.pit_a, ifa.pit_a};
  assign dout = {ifb.pit_d_out, ifa.pit_d_out};
  assign rdat = {ifb.rsp_data, ifa.rsp_data};
  assign stb  = ~(rd_n & wr_n);

  int total = 0;
  int bad = 0;

  // Monitor / timer model state (written only by the monitor process)
  logic [1:0] p_cs = 2'b11, p_stb = 2'b00;
  int pre_c[2], post_c[2], slen[2], cs_lo[2];
  logic [1:0] la[2];
  logic [7:0] ld[2];
  int viol = 0;
  int rd_cnt = 0;
  logic       ev_rd[$];
  logic [1:0] ev_a[$];
  logic [7:0] ev_d[$];
  int         sl_q[$];

  // Written only by the stimulus process
  int act = 0;
  int rd_at = 0;
  logic [7:0] rv0 = 0, rv1 = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rd_n[i] && !wr_n[i]) viol++;
      if (!rd_n[i] && d_oe[i]) viol++;
      if (stb[i] && cs_n[i]) viol++;
      if (!cs_n[i]) begin
        cs_lo[i]++;
        if (p_cs[i]) begin
          la[i] = pa[i]; ld[i] = dout[i]; pre_c[i] = 0; post_c[i] = 0; slen[i] = 0;
        end else if (pa[i] !== la[i] || dout[i] !== ld[i]) viol++;
        if (stb[i]) begin
          if (!p_stb[i]) begin
            if (pre_c[i] != SETUP) viol++;
            if (i == act) begin
              ev_rd.push_back(!rd_n[i]); ev_a.push_back(pa[i]); ev_d.push_back(dout[i]);
              if (!rd_n[i]) begin
                d_in = (rd_cnt - rd_at == 0) ? rv0 : ((rd_cnt - rd_at == 1) ? rv1 : 8'hEE);
                rd_cnt++;
              end
            end
          end
          slen[i]++;
        end else if (slen[i] == 0) pre_c[i]++;
        else post_c[i]++;
      end else begin
        if (d_oe[i]) viol++;
        if (!p_cs[i]) begin
          if (post_c[i] != HOLD) viol++;
          if (i == act) sl_q.push_back(slen[i]);
        end
      end
      p_cs[i] = cs_n[i];
      p_stb[i] = stb[i];
    end
    if (&rd_n) d_in = 8'($urandom);
  end

  task automatic do_cmd(input int inst, input logic [1:0] op, input logic [1:0] sel,
                        input logic [2:0] mode, input logic bcd, input logic [1:0] rw,
                        input logic [15:0] cnt, input logic [7:0] r0, input logic [7:0] r1);
    logic ok, got, early;
    int n, L, st, lat, exp_lat, eb, sb, v0, c0;
    logic [15:0] exp;
    logic       xr[$];
    logic [1:0] xa[$];
    logic [7:0] xd[$];
    L  = inst ? 6 : 5;
    st = inst ? 3 : 2;
    ok = (op != 2'b11) && (sel != 2'b11) && !(op != 2'b10 && rw == 2'b00);
    exp = 16'h0000;
    if (ok) begin
      case (op)
        2'b00: begin
          xr.push_back(0); xa.push_back(2'd3); xd.push_back({sel, rw, mode, bcd});
          if (rw[0]) begin xr.push_back(0); xa.push_back(sel); xd.push_back(cnt[7:0]); end
          if (rw[1]) begin xr.push_back(0); xa.push_back(sel); xd.push_back(cnt[15:8]); end
        end
        2'b01: begin
          xr.push_back(0); xa.push_back(2'd3); xd.push_back({sel, 6'b0});
          for (int k = 0; k < ((rw == 2'b11) ? 2 : 1); k++) begin
            xr.push_back(1); xa.push_back(sel); xd.push_back(8'h00);
          end
          case (rw)
            2'b01:   exp = {8'h00, r0};
            2'b10:   exp = {r0, 8'h00};
            default: exp = {r1, r0};
          endcase
        end
        default: begin
          xr.push_back(0); xa.push_back(2'd3);
          xd.push_back({2'b11, 1'b1, 1'b0, sel == 2'd2, sel == 2'd1, sel == 2'd0, 1'b0});
          xr.push_back(1); xa.push_back(sel); xd.push_back(8'h00);
          exp = {8'h00, r0};
        end
      endcase
    end
    n = xr.size();
    exp_lat = ok ? n * L + 1 : 1;

    @(negedge clk); #1;
    eb = ev_a.size(); sb = sl_q.size(); v0 = viol; c0 = cs_lo[inst];
    act = inst; rd_at = rd_cnt; rv0 = r0; rv1 = r1;
    c_op = op; c_sel = sel; c_mode = mode; c_bcd = bcd; c_rw = rw; c_cnt = cnt;
    cv[inst] = 1'b1;
    total++;
    if (rdy[inst] !== 1'b1) begin bad++; $display("FAIL ready_before: got %b want 1", rdy[inst]); end
    @(posedge clk); #1;
    cv[inst] = 1'b0;
    c_op = 2'($urandom); c_sel = 2'($urandom); c_mode = 3'($urandom);
    c_bcd = 1'($urandom); c_rw = 2'($urandom); c_cnt = 16'($urandom);

    lat = 0; got = 0; early = 0;
    while (!got && lat < 200) begin
      @(negedge clk); lat++;
      if (rv[inst]) got = 1;
      else if (rdy[inst]) early = 1;
    end
    total++;
    if (!got || lat != exp_lat) begin
      bad++; $display("FAIL latency: got %0d want %0d (op=%0d sel=%0d rw=%0d)", got ? lat : -1, exp_lat, op, sel, rw);
    end
    total++;
    if (early || rdy[inst] !== 1'b0) begin bad++; $display("FAIL ready_busy: early=%0d ready=%b want 0", early, rdy[inst]); end
    total++;
    if (re[inst] !== !ok || rdat[inst] !== exp) begin
      bad++; $display("FAIL response: err=%b data=%h want err=%b data=%h", re[inst], rdat[inst], !ok, exp);
    end
    @(negedge clk);
    total++;
    if (rv[inst] !== 1'b0 || rdy[inst] !== 1'b1 || rdat[inst] !== exp) begin
      bad++; $display("FAIL after_resp: valid=%b ready=%b data=%h want 0 1 %h", rv[inst], rdy[inst], rdat[inst], exp);
    end

    total++;
    if (ev_a.size() - eb != n || sl_q.size() - sb != n) begin
      bad++; $display("FAIL bus_count: got %0d/%0d want %0d", ev_a.size() - eb, sl_q.size() - sb, n);
    end
    for (int k = 0; k < n && eb + k < ev_a.size(); k++) begin
      total++;
      if (ev_rd[eb+k] !== xr[k] || ev_a[eb+k] !== xa[k] || (!xr[k] && ev_d[eb+k] !== xd[k])) begin
        bad++; $display("FAIL bus_cycle%0d: rd=%b a=%0d d=%h want rd=%b a=%0d d=%h", k,
                        ev_rd[eb+k], ev_a[eb+k], ev_d[eb+k], xr[k], xa[k], xd[k]);
      end
    end
    for (int k = sb; k < sl_q.size(); k++) begin
      total++;
      if (sl_q[k] != st) begin bad++; $display("FAIL strobe_len: got %0d want %0d", sl_q[k], st); end
    end
    total++;
    if (viol != v0 || cs_lo[inst] - c0 != n * (SETUP + st + HOLD)) begin
      bad++; $display("FAIL bus_protocol: violations=%0d cs_low=%0d want 0 %0d", viol - v0,
                      cs_lo[inst] - c0, n * (SETUP + st + HOLD));
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (cs_n[i] !== 1 || rd_n[i] !== 1 || wr_n[i] !== 1 || d_oe[i] !== 0 || pa[i] !== 0 ||
          dout[i] !== 0 || rv[i] !== 0 || re[i] !== 0 || rdat[i] !== 0 || rdy[i] !== 1) begin
        bad++; $display("FAIL reset%0d: cs=%b rd=%b wr=%b oe=%b a=%0d d=%h v=%b e=%b data=%h rdy=%b",
                        i, cs_n[i], rd_n[i], wr_n[i], d_oe[i], pa[i], dout[i], rv[i], re[i], rdat[i], rdy[i]);
      end
    end
    @(negedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_cmd(0, 2'b00, 2'd0, 3'd0, 1'b0, 2'b01, 16'h0010, 8'h00, 8'h00);
    do_cmd(0, 2'b00, 2'd1, 3'd3, 1'b0, 2'b11, 16'h1234, 8'h00, 8'h00);
    do_cmd(0, 2'b01, 2'd2, 3'd0, 1'b0, 2'b11, 16'h0000, 8'hCD, 8'hAB);
    do_cmd(0, 2'b10, 2'd1, 3'd0, 1'b0, 2'b00, 16'h0000, 8'h96, 8'h00);
    do_cmd(0, 2'b01, 2'd0, 3'd0, 1'b0, 2'b10, 16'h0000, 8'h5A, 8'h00);
    do_cmd(0, 2'b00, 2'd2, 3'd5, 1'b1, 2'b10, 16'hBEEF, 8'h00, 8'h00);
  endtask

  task automatic test_illegal();
    do_cmd(0, 2'b00, 2'd3, 3'd2, 1'b0, 2'b01, 16'h1111, 8'h00, 8'h00);
    do_cmd(0, 2'b11, 2'd0, 3'd2, 1'b0, 2'b01, 16'h2222, 8'h00, 8'h00);
    do_cmd(0, 2'b00, 2'd0, 3'd2, 1'b0, 2'b00, 16'h3333, 8'h00, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic hit, seen;
    int eb;
    @(negedge clk); #1;
    eb = ev_a.size(); act = 0;
    c_op = 2'b00; c_sel = 2'd2; c_mode = 3'd2; c_bcd = 1'b0; c_rw = 2'b11; c_cnt = 16'($urandom);
    cv[0] = 1'b1;
    @(posedge clk); #1 cv[0] = 1'b0;
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk); #1;
      if (ev_a.size() - eb == 2 && !wr_n[0]) hit = 1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL reset_mid_reach: got 0 want 1"); end
    rst_n = 1'b0;
    #1;
    total++;
    if (cs_n[0] !== 1 || wr_n[0] !== 1 || d_oe[0] !== 0 || rdy[0] !== 1 || rv[0] !== 0) begin
      bad++; $display("FAIL reset_mid: cs=%b wr=%b oe=%b rdy=%b v=%b want 1 1 0 1 0",
                      cs_n[0], wr_n[0], d_oe[0], rdy[0], rv[0]);
    end
    seen = 0;
    repeat (3) begin @(negedge clk); if (rv[0] || !cs_n[0]) seen = 1; end
    #1 rst_n = 1'b1;
    repeat (12) begin @(negedge clk); if (rv[0] || !cs_n[0]) seen = 1; end
    total++;
    if (seen) begin bad++; $display("FAIL reset_mid_quiet: got 1 want 0"); end
    do_cmd(0, 2'b00, 2'd1, 3'd4, 1'b1, 2'b11, 16'hA55A, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    logic [1:0] op, sel;
    for (int k = 0; k < 40; k++) begin
      op  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      sel = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_cmd(0, op, sel, 3'($urandom), 1'($urandom), 2'($urandom), 16'($urandom),
             8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_strobe3();
    do_cmd(1, 2'b00, 2'd0, 3'd0, 1'b0, 2'b01, 16'h0010, 8'h00, 8'h00);
    do_cmd(1, 2'b01, 2'd1, 3'd0, 1'b0, 2'b11, 16'h0000, 8'h3C, 8'hC3);
    do_cmd(1, 2'b11, 2'd1, 3'd0, 1'b0, 2'b11, 16'h0000, 8'h00, 8'h00);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_reset_mid();
    test_random();
    test_strobe3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
